nfc_atom_ca_latch: RTL and testbench
====================================

# nfc_atom_ca_latch

Atomic command/address latch generator, the "CA" atom at ACG bit 6. It sits directly downstream of the NAND command FSMs (set-feature, reset, read, program), through the ACG arbiter. It accepts one CA request (1–5 bytes, command or address), drives the NAND-side CE_n/CLE/ALE/WE_n/DQ pins with programmable WE_n pulse timing, and reports completion through a one-cycle last-step pulse.

## Interface
- NumberOfWays, 4, number of chip-enable ways
- WPCycles, 2, WE_n low width in clocks (1..15)
- WHCycles, 2, WE_n high width in clocks (1..15)

Ports:
- iSystemClock  in  1  system clock
- iReset  in  1  synchronous, active-low reset
- iStart  in  1  request; ACG command bit 6 from arbiter
- oReady  out  1  idle; feeds iACG_Ready[6]
- oLastStep  out  1  one-cycle done pulse; feeds iACG_LastStep[6]
- iTargetWay  in  NumberOfWays  one-hot way select
- iNumOfData  in  16  byte count
- iCASelect  in  1  1 = command (CLE), 0 = address (ALE)
- iCAData  in  40  bytes, issued [39:32] first
- oPO_CE_n  out  NumberOfWays  active-low chip enables
- oPO_CLE  out  1  command latch enable
- oPO_ALE  out  1  address latch enable
- oPO_WE_n  out  1  write enable, active low
- oPO_DQ  out  8  data bus
- oPO_DQOE  out  1  DQ output enable

## Operation
- One-hot FSM with states IDLE, SETUP, WE_LOW, WE_HIGH, HOLD, DONE.
- IDLE: oReady=1. iStart=1 captures iTargetWay, iCASelect, iCAData and the clamped count, then moves to SETUP. iStart is sampled only in IDLE.
- Count clamp: 0→1, >5→5, using iNumOfData[15:0] compared unsigned. The byte counter is 3 bits.
- SETUP (1 cycle):
  - CE_n = ~way.
  - CLE = CASelect, ALE = ~CASelect.
  - DQ = current byte, DQOE=1, WE_n=1.
- WE_LOW: WE_n=0 for WPCycles. Then WE_HIGH.
- WE_HIGH: WE_n=1 for WHCycles, with DQ unchanged (NAND latches on the rising edge).
  - Then, if bytes remain: shift to the next byte and go to WE_LOW.
  - Otherwise go to HOLD.
- HOLD (1 cycle): CE/CLE/ALE/DQ held, WE_n=1.
- DONE (1 cycle): oLastStep=1, oReady=0. CE_n all 1, CLE=ALE=0, DQOE=0. Then IDLE.
- oReady stays low during DONE so the upstream FSM can update its registered command and CA data before the next acceptance. A stale iStart held across DONE must not re-issue.
- iTargetWay=0 is legal: the full sequence runs with CE_n all 1, and oLastStep still pulses.
- All outputs are registered.

## Timing
- Reset values: oReady=1, oLastStep=0, oPO_CE_n=all 1, oPO_CLE=0, oPO_ALE=0, oPO_WE_n=1, oPO_DQ=0, oPO_DQOE=0.
- Let the accept edge be cycle 0, N = clamped count, p = WPCycles, h = WHCycles.
  - SETUP at cycle 1.
  - Byte k: WE_n low in cycles 2+k(p+h) .. 1+k(p+h)+p.
  - HOLD at cycle 2+N(p+h).
  - oLastStep at cycle 3+N(p+h).
  - oReady=1 at cycle 4+N(p+h).
- Defaults with N=1: oLastStep at cycle 7. With N=5: cycle 23.
- Minimum accept-to-accept spacing: 4+N(p+h) cycles.
- Reset asserted mid-operation: on the next edge all outputs take their reset values and the FSM goes to IDLE. No oLastStep is produced.
- WPCycles or WHCycles outside 1..15 is an elaboration error.

## Structure
- Shared package nfc_atom_pkg holds:
  - ACG bit indices (CA latch=6, data out=5).
  - One-hot state localparams for this atom.
  - Max CA byte count (5).
- Sub-module nfc_phase_timer: 4-bit loadable down-counter with load/value inputs and a zero flag. It is reused for the WE_LOW and WE_HIGH phases.

## Test plan
- Reset: iReset=0 for 3 cycles with iStart=1 → all reset values hold; oReady=1 after release; no pin activity.
- Single command: CAData=40'hEF_00_00_00_00, CASelect=1, way 4'b0010, N=1, defaults → CE_n=4'b1101, CLE=1, DQ=8'hEF, WE_n low in cycles 2–3, oLastStep at cycle 7, oReady at cycle 8.
- Address burst: CAData=40'h01_02_03_04_05, CASelect=0, N=5 → ALE=1, five WE_n pulses, DQ sequence 01,02,03,04,05, oLastStep at cycle 23.
- Back-to-back (set-feature pattern): iStart held high from EFh through 01h with data switched in the DONE cycle → exactly two operations, second DQ=8'h01, second accept one cycle after oLastStep.
- Clamp: iNumOfData=0 → one WE_n pulse; iNumOfData=9 → five pulses.
- Mid-op reset: iReset=0 during byte-2 WE_LOW → next cycle WE_n=1, CE_n all 1, DQOE=0, no oLastStep, oReady=1 after release.

Source files
------------

// File: rtl/nfc_atom_pkg.sv
// Shared definitions for the NAND atomic command generators (ACG atoms).
// Holds ACG bit positions, CA latch FSM state encoding and the CA byte-count clamp.
package nfc_atom_pkg;

  localparam int ACG_BIT_DATA_OUT = 5;
  localparam int ACG_BIT_CA_LATCH = 6;

  localparam int CA_MAX_BYTES = 5;

  typedef enum logic [5:0] {
    CA_IDLE    = 6'b000001,
    CA_SETUP   = 6'b000010,
    CA_WE_LOW  = 6'b000100,
    CA_WE_HIGH = 6'b001000,
    CA_HOLD    = 6'b010000,
    CA_DONE    = 6'b100000
  } ca_state_e;

  // A zero count still issues one byte; anything above the CA width saturates.
  function automatic logic [2:0] ca_clamp_count(input logic [15:0] num);
    if (num == 16'd0) begin
      return 3'd1;
    end
    if (num > 16'(CA_MAX_BYTES)) begin
      return 3'(CA_MAX_BYTES);
    end
    return num[2:0];
  endfunction

endpackage

// File: rtl/nfc_phase_timer.sv
// Loadable 4-bit down-counter that times one WE_n phase; zero_o marks the phase's last cycle.
module nfc_phase_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] value_i,
  output logic       zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/nfc_atom_ca_latch.sv
// CA latch atom (ACG bit 6): issues 1..5 command or address bytes onto the NAND pins
// with programmable WE_n low/high widths and pulses oLastStep when the sequence is done.
module nfc_atom_ca_latch
  import nfc_atom_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int WPCycles     = 2,
  parameter int WHCycles     = 2
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iStart,
  output logic                    oReady,
  output logic                    oLastStep,
  input  logic [NumberOfWays-1:0] iTargetWay,
  input  logic [15:0]             iNumOfData,
  input  logic                    iCASelect,
  input  logic [39:0]             iCAData,
  output logic [NumberOfWays-1:0] oPO_CE_n,
  output logic                    oPO_CLE,
  output logic                    oPO_ALE,
  output logic                    oPO_WE_n,
  output logic [7:0]              oPO_DQ,
  output logic                    oPO_DQOE
);

  if (WPCycles < 1 || WPCycles > 15) begin : g_bad_wp
    $error("nfc_atom_ca_latch: WPCycles must be within 1..15");
  end
  if (WHCycles < 1 || WHCycles > 15) begin : g_bad_wh
    $error("nfc_atom_ca_latch: WHCycles must be within 1..15");
  end

  // The timer expires on the last cycle of a phase, so it is loaded with width-1.
  localparam logic [3:0] WpLoad = 4'(WPCycles - 1);
  localparam logic [3:0] WhLoad = 4'(WHCycles - 1);

  ca_state_e               state_q;
  logic [39:0]             data_q;
  logic [2:0]              count_q;
  logic                    ready_q;
  logic                    last_q;
  logic [NumberOfWays-1:0] ce_n_q;
  logic                    cle_q;
  logic                    ale_q;
  logic                    we_n_q;
  logic [7:0]              dq_q;
  logic                    dqoe_q;

  logic                    timerLoad_d;
  logic [3:0]              timerValue_d;
  logic                    timerZero;

  nfc_phase_timer u_phase_timer (
    .clk_i   (iSystemClock),
    .rst_ni  (iReset),
    .load_i  (timerLoad_d),
    .value_i (timerValue_d),
    .zero_o  (timerZero)
  );

  always_comb begin
    timerLoad_d  = 1'b0;
    timerValue_d = WpLoad;
    case (state_q)
      CA_SETUP:   timerLoad_d = 1'b1;
      CA_WE_LOW: begin
        timerLoad_d  = timerZero;
        timerValue_d = WhLoad;
      end
      CA_WE_HIGH: timerLoad_d = timerZero && (count_q > 3'd1);
      default:    timerLoad_d = 1'b0;
    endcase
  end

  // Pin registers are written together with the state, so each state's pin values
  // appear in the cycle right after the edge that enters it.
  always_ff @(posedge iSystemClock) begin
    if (!iReset) begin
      state_q <= CA_IDLE;
      data_q  <= 40'd0;
      count_q <= 3'd0;
      ready_q <= 1'b1;
      last_q  <= 1'b0;
      ce_n_q  <= '1;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      we_n_q  <= 1'b1;
      dq_q    <= 8'd0;
      dqoe_q  <= 1'b0;
    end else begin
      case (state_q)
        CA_IDLE: begin
          if (iStart) begin
            state_q <= CA_SETUP;
            data_q  <= iCAData;
            count_q <= ca_clamp_count(iNumOfData);
            ready_q <= 1'b0;
            ce_n_q  <= ~iTargetWay;
            cle_q   <= iCASelect;
            ale_q   <= ~iCASelect;
            we_n_q  <= 1'b1;
            dq_q    <= iCAData[39:32];
            dqoe_q  <= 1'b1;
          end
        end
        CA_SETUP: begin
          state_q <= CA_WE_LOW;
          we_n_q  <= 1'b0;
        end
        CA_WE_LOW: begin
          if (timerZero) begin
            state_q <= CA_WE_HIGH;
            we_n_q  <= 1'b1;
          end
        end
        CA_WE_HIGH: begin
          if (timerZero) begin
            if (count_q > 3'd1) begin
              state_q <= CA_WE_LOW;
              count_q <= count_q - 3'd1;
              data_q  <= {data_q[31:0], 8'h00};
              dq_q    <= data_q[31:24];
              we_n_q  <= 1'b0;
            end else begin
              state_q <= CA_HOLD;
            end
          end
        end
        CA_HOLD: begin
          state_q <= CA_DONE;
          last_q  <= 1'b1;
          ce_n_q  <= '1;
          cle_q   <= 1'b0;
          ale_q   <= 1'b0;
          dqoe_q  <= 1'b0;
        end
        CA_DONE: begin
          // Ready rises only after DONE so a stale iStart cannot re-trigger.
          state_q <= CA_IDLE;
          last_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CA_IDLE;
          ready_q <= 1'b1;
          last_q  <= 1'b0;
          ce_n_q  <= '1;
          cle_q   <= 1'b0;
          ale_q   <= 1'b0;
          we_n_q  <= 1'b1;
          dqoe_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oReady    = ready_q;
  assign oLastStep = last_q;
  assign oPO_CE_n  = ce_n_q;
  assign oPO_CLE   = cle_q;
  assign oPO_ALE   = ale_q;
  assign oPO_WE_n  = we_n_q;
  assign oPO_DQ    = dq_q;
  assign oPO_DQOE  = dqoe_q;

endmodule

// File: tb/tb_nfc_atom_ca_latch.sv
// Scoreboard bench for nfc_atom_ca_latch: the driver queues expected CA transactions,
// the monitor rebuilds each transaction from the NAND pins and checks it at oLastStep.
module tb_nfc_atom_ca_latch;

  localparam int W = 4;
  localparam int P = 2;
  localparam int H = 2;

  logic          clk = 1'b0;
  logic          iReset;
  logic          iStart;
  logic          oReady;
  logic          oLastStep;
  logic [W-1:0]  iTargetWay;
  logic [15:0]   iNumOfData;
  logic          iCASelect;
  logic [39:0]   iCAData;
  logic [W-1:0]  oPO_CE_n;
  logic          oPO_CLE;
  logic          oPO_ALE;
  logic          oPO_WE_n;
  logic [7:0]    oPO_DQ;
  logic          oPO_DQOE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int           acceptCyc;
    int           n;
    logic [39:0]  data;
    logic [W-1:0] ceN;
    logic         cle;
    logic         ale;
  } exp_t;

  exp_t expQ[$];

  logic [7:0]   obsByte[$];
  int           obsLow[$];
  int           obsGap[$];
  logic [W+2:0] obsPins[$];
  logic         prevWe = 1'b1;
  int           lowRun = 0;
  int           highRun = 0;
  bit           checkReadyNext = 1'b0;
  exp_t         cur;

  nfc_atom_ca_latch #(
    .NumberOfWays (W),
    .WPCycles     (P),
    .WHCycles     (H)
  ) dut (
    .iSystemClock (clk),
    .iReset       (iReset),
    .iStart       (iStart),
    .oReady       (oReady),
    .oLastStep    (oLastStep),
    .iTargetWay   (iTargetWay),
    .iNumOfData   (iNumOfData),
    .iCASelect    (iCASelect),
    .iCAData      (iCAData),
    .oPO_CE_n     (oPO_CE_n),
    .oPO_CLE      (oPO_CLE),
    .oPO_ALE      (oPO_ALE),
    .oPO_WE_n     (oPO_WE_n),
    .oPO_DQ       (oPO_DQ),
    .oPO_DQOE     (oPO_DQOE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int clampModel(input int num);
    if (num < 1) return 1;
    if (num > 5) return 5;
    return num;
  endfunction

  task automatic checkIdlePins(input string tag);
    checkOutput({tag, "_ready"}, 64'(oReady), 64'd1);
    checkOutput({tag, "_last"}, 64'(oLastStep), 64'd0);
    checkOutput({tag, "_ce_n"}, 64'(oPO_CE_n), 64'hF);
    checkOutput({tag, "_cle"}, 64'(oPO_CLE), 64'd0);
    checkOutput({tag, "_ale"}, 64'(oPO_ALE), 64'd0);
    checkOutput({tag, "_we_n"}, 64'(oPO_WE_n), 64'd1);
    checkOutput({tag, "_dq"}, 64'(oPO_DQ), 64'd0);
    checkOutput({tag, "_dqoe"}, 64'(oPO_DQOE), 64'd0);
  endtask

  task automatic waitReady();
    int k = 0;
    while (oReady !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (oReady !== 1'b1) checkOutput("ready_timeout", 64'(oReady), 64'd1);
  endtask

  task automatic waitDrain();
    int k = 0;
    while (expQ.size() > 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (expQ.size() > 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic exp_t makeExp(input int acceptCyc, input logic [W-1:0] way, input logic sel,
                                   input logic [15:0] num, input logic [39:0] data);
    exp_t x;
    x.acceptCyc = acceptCyc;
    x.n         = clampModel(int'(num));
    x.data      = data;
    x.ceN       = ~way;
    x.cle       = sel;
    x.ale       = ~sel;
    return x;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] way, input logic sel, input logic [15:0] num,
                               input logic [39:0] data, input bit push);
    waitReady();
    iTargetWay = way;
    iCASelect  = sel;
    iNumOfData = num;
    iCAData    = data;
    iStart     = 1'b1;
    if (push) expQ.push_back(makeExp(cyc + 1, way, sel, num, data));
    @(negedge clk);
    iStart     = 1'b0;
    iTargetWay = W'($urandom);
    iCASelect  = 1'($urandom);
    iNumOfData = 16'($urandom);
    iCAData    = {8'($urandom), 32'($urandom)};
  endtask

  // Monitor: reconstructs WE_n pulses and compares against the scoreboard at oLastStep.
  always @(negedge clk) begin
    if (iReset !== 1'b1) begin
      obsByte.delete();
      obsLow.delete();
      obsGap.delete();
      obsPins.delete();
      prevWe = 1'b1;
      lowRun = 0;
      highRun = 0;
      checkReadyNext = 1'b0;
    end else begin
      if (checkReadyNext) begin
        checkOutput("ready_after_done", 64'(oReady), 64'd1);
        checkReadyNext = 1'b0;
      end
      if (oPO_WE_n === 1'b0) begin
        if (prevWe === 1'b1 && obsByte.size() > 0) obsGap.push_back(highRun);
        lowRun++;
      end else begin
        if (prevWe === 1'b0) begin
          obsLow.push_back(lowRun);
          obsByte.push_back(oPO_DQ);
          obsPins.push_back({oPO_CE_n, oPO_CLE, oPO_ALE, oPO_DQOE});
          lowRun = 0;
          highRun = 0;
        end
        highRun++;
      end
      prevWe = oPO_WE_n;
      if (oLastStep === 1'b1) begin
        checkOutput("done_ready_low", 64'(oReady), 64'd0);
        checkOutput("done_ce_n", 64'(oPO_CE_n), 64'hF);
        checkOutput("done_cle_ale", 64'({oPO_CLE, oPO_ALE}), 64'd0);
        checkOutput("done_dqoe", 64'(oPO_DQOE), 64'd0);
        checkOutput("pending_request", 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
          cur = expQ.pop_front();
          checkOutput("laststep_cycle", 64'(cyc), 64'(cur.acceptCyc + 2 + cur.n * (P + H)));
          checkOutput("pulse_count", 64'(obsByte.size()), 64'(cur.n));
          for (int i = 0; i < cur.n && i < obsByte.size(); i++) begin
            checkOutput($sformatf("byte%0d_dq", i), 64'(obsByte[i]), 64'(cur.data[39-8*i -: 8]));
            checkOutput($sformatf("byte%0d_we_low", i), 64'(obsLow[i]), 64'(P));
            checkOutput($sformatf("byte%0d_pins", i), 64'(obsPins[i]),
                        64'({cur.ceN, cur.cle, cur.ale, 1'b1}));
          end
          checkOutput("gap_count", 64'(obsGap.size()), 64'(cur.n - 1));
          foreach (obsGap[i]) checkOutput($sformatf("gap%0d_we_high", i), 64'(obsGap[i]), 64'(H));
        end
        obsByte.delete();
        obsLow.delete();
        obsGap.delete();
        obsPins.delete();
        checkReadyNext = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] way;
    logic [15:0]  num;
    int           k;

    iReset     = 1'b0;
    iStart     = 1'b1;
    iTargetWay = 4'b0010;
    iNumOfData = 16'd1;
    iCASelect  = 1'b1;
    iCAData    = 40'hEF_00_00_00_00;

    repeat (3) begin
      @(negedge clk);
      checkIdlePins("reset");
    end
    iReset = 1'b1;
    iStart = 1'b0;
    @(negedge clk);
    checkIdlePins("post_reset");

    $display("[TB] single command");
    applyStimulus(4'b0010, 1'b1, 16'd1, 40'hEF_00_00_00_00, 1'b1);
    waitDrain();

    $display("[TB] address burst");
    applyStimulus(4'b0100, 1'b0, 16'd5, 40'h01_02_03_04_05, 1'b1);
    waitDrain();

    $display("[TB] back-to-back with held iStart");
    waitReady();
    iTargetWay = 4'b0001;
    iCASelect  = 1'b1;
    iNumOfData = 16'd1;
    iCAData    = 40'hEF_00_00_00_00;
    iStart     = 1'b1;
    expQ.push_back(makeExp(cyc + 1, 4'b0001, 1'b1, 16'd1, 40'hEF_00_00_00_00));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (oLastStep !== 1'b1 && k < 100);
    checkOutput("b2b_first_laststep_seen", 64'(oLastStep), 64'd1);
    iCASelect = 1'b0;
    iCAData   = 40'h01_00_00_00_00;
    expQ.push_back(makeExp(cyc + 2, 4'b0001, 1'b0, 16'd1, 40'h01_00_00_00_00));
    repeat (2) @(negedge clk);
    iStart = 1'b0;
    waitDrain();
    repeat (30) @(negedge clk);

    $display("[TB] clamp cases");
    applyStimulus(4'b1000, 1'b0, 16'd0, 40'hA5_11_22_33_44, 1'b1);
    waitDrain();
    applyStimulus(4'b0001, 1'b0, 16'd9, 40'h5A_C3_3C_96_69, 1'b1);
    waitDrain();
    applyStimulus(4'b0010, 1'b1, 16'hFFFF, 40'h12_34_56_78_9A, 1'b1);
    waitDrain();

    $display("[TB] no way selected");
    applyStimulus(4'b0000, 1'b1, 16'd2, 40'h70_80_00_00_00, 1'b1);
    waitDrain();

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      way = W'(1 << $urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0:       num = 16'($urandom_range(0, 8));
        1:       num = 16'($urandom);
        default: num = 16'($urandom_range(1, 5));
      endcase
      applyStimulus(way, 1'($urandom), num, {8'($urandom), 32'($urandom)}, 1'b1);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    waitDrain();

    $display("[TB] reset during second byte");
    applyStimulus(4'b0100, 1'b0, 16'd3, 40'hDE_AD_BE_EF_00, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("midop_we_low_before_reset", 64'(oPO_WE_n), 64'd0);
    iReset = 1'b0;
    @(negedge clk);
    checkIdlePins("midop_reset");
    @(negedge clk);
    iReset = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("midop_ready_after_release", 64'(oReady), 64'd1);

    waitDrain();
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
